// File: rtl/run_pattern_gen_if.sv
// Command and observation bundle between a stimulus driver and the run pattern generator.
// The generator connects through the slave modport and the driver through the master modport.
interface run_pattern_gen_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [LEN_W-1:0] cmd_gap;
    logic             X;
    logic             busy;
    logic             done;
    logic             pred_z1;
    logic             pred_z2;
    logic [CNT_W-1:0] run_count;

    modport master (
        output cmd_valid, cmd_len, cmd_gap,
        input  cmd_ready, X, busy, done, pred_z1, pred_z2, run_count
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_gap,
        output cmd_ready, X, busy, done, pred_z1, pred_z2, run_count
    );
endinterface

// File: rtl/run_pattern_gen.sv
// Drives serial X runs (LEN high, then max(GAP,1) low) and shadows the detector's
// two-high-cycle rule to predict its Z1/Z2 outputs in step with X.
module run_pattern_gen #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    run_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic [LEN_W-1:0] r_gap;
    logic [LEN_W-1:0] w_gap_nxt;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_h1;
    logic             r_h2;
    logic [CNT_W-1:0] r_run_count;
    logic             w_ready;
    logic             w_accept;
    logic             w_pred_z1;
    logic             w_pred_z2;

    // A zero gap still costs one LOW cycle, so the reload value floors at zero.
    function automatic logic [LEN_W-1:0] gap_reload(input logic [LEN_W-1:0] gap);
        logic [LEN_W-1:0] reload;
        if (gap == {LEN_W{1'b0}}) begin
            reload = {LEN_W{1'b0}};
        end else begin
            reload = gap - {{(LEN_W-1){1'b0}}, 1'b1};
        end
        return reload;
    endfunction

    assign w_ready  = (r_state == ST_IDLE) && !reset;
    assign w_accept = bus.cmd_valid && w_ready;

    // Next-state, counter reload and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_gap_nxt = bus.cmd_gap;
                    if (bus.cmd_len != {LEN_W{1'b0}}) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = bus.cmd_len - {{(LEN_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = gap_reload(bus.cmd_gap);
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (r_cnt == {LEN_W{1'b0}}) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = gap_reload(r_gap);
                end else begin
                    w_cnt_nxt = r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                end
            end
            ST_LOW: begin
                if (r_cnt == {LEN_W{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {LEN_W{1'b0}};
            end
        endcase
    end

    // State register; X and busy are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {LEN_W{1'b0}};
            r_gap   <= {LEN_W{1'b0}};
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_x     <= (w_state_nxt == ST_HIGH);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    // Detector outputs are Mealy on X, so the predictions stay combinational from registers.
    assign w_pred_z2 = r_h1 & r_h2 & r_x;
    assign w_pred_z1 = r_h1 & r_h2 & ~r_x;

    // Shadow X history and saturating count of predicted Z1 events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h1        <= 1'b0;
            r_h2        <= 1'b0;
            r_run_count <= {CNT_W{1'b0}};
        end else begin
            r_h1 <= r_x;
            r_h2 <= r_h1;
            if (w_pred_z1 && (r_run_count != {CNT_W{1'b1}})) begin
                r_run_count <= r_run_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_run_count <= r_run_count;
            end
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.X         = r_x;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pred_z1   = w_pred_z1;
    assign bus.pred_z2   = w_pred_z2;
    assign bus.run_count = r_run_count;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Directed bench for run_pattern_gen: hand-computed per-cycle X / pred / done / busy
// patterns, back-to-back acceptance, mid-run reset and run_count saturation.
module tb_run_pattern_gen;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    run_pattern_gen_if #(.LEN_W(4), .CNT_W(8)) bus ();

    run_pattern_gen #(.LEN_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a command in the current cycle (cycle 0) and checks cycles 1..ncyc.
    // Bit c of each pattern is the expected value in cycle c after the accepting edge.
    task automatic run_cmd(input string name, input logic [3:0] len, input logic [3:0] gap,
                           input int ncyc, input int drop_at,
                           input logic [15:0] ex, input logic [15:0] ez1,
                           input logic [15:0] ez2, input logic [15:0] edone,
                           input logic [15:0] ebusy);
        bus.cmd_len   = len;
        bus.cmd_gap   = gap;
        bus.cmd_valid = 1'b1;
        chk($sformatf("%s ready c0", name), bus.cmd_ready, 32'd1);
        for (int c = 1; c <= ncyc; c++) begin
            step();
            chk($sformatf("%s X c%0d", name, c),    bus.X,       ex[c]);
            chk($sformatf("%s z1 c%0d", name, c),   bus.pred_z1, ez1[c]);
            chk($sformatf("%s z2 c%0d", name, c),   bus.pred_z2, ez2[c]);
            chk($sformatf("%s done c%0d", name, c), bus.done,    edone[c]);
            chk($sformatf("%s busy c%0d", name, c), bus.busy,    ebusy[c]);
            if (c == drop_at) bus.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 4'd0;
        bus.cmd_gap   = 4'd0;

        // Reset state
        repeat (3) step();
        chk("rst X",       bus.X,         32'd0);
        chk("rst busy",    bus.busy,      32'd0);
        chk("rst done",    bus.done,      32'd0);
        chk("rst z1",      bus.pred_z1,   32'd0);
        chk("rst z2",      bus.pred_z2,   32'd0);
        chk("rst count",   bus.run_count, 32'd0);
        chk("rst ready",   bus.cmd_ready, 32'd0);
        reset = 1'b0;
        #1;
        chk("post rst ready", bus.cmd_ready, 32'd1);

        // len=1 gap=1: X in c1, LOW c2, done c3
        run_cmd("l1g1", 4'd1, 4'd1, 3, 1, 16'h0002, 16'h0000, 16'h0000, 16'h0008, 16'h0006);
        chk("l1g1 count", bus.run_count, 32'd0);

        // len=2 gap=3: X c1-2, z1 c3, done c6
        run_cmd("l2g3", 4'd2, 4'd3, 6, 1, 16'h0006, 16'h0008, 16'h0000, 16'h0040, 16'h003E);
        chk("l2g3 count", bus.run_count, 32'd1);

        // len=5 gap=2: X c1-5, z2 c3-5, z1 c6, done c8
        run_cmd("l5g2", 4'd5, 4'd2, 8, 1, 16'h003E, 16'h0040, 16'h0038, 16'h0100, 16'h00FE);
        chk("l5g2 count", bus.run_count, 32'd2);

        // len=0 gap=0: one LOW cycle, done c2
        run_cmd("l0g0", 4'd0, 4'd0, 2, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0002);
        chk("l0g0 count", bus.run_count, 32'd2);

        // Two len=3 gap=1 commands with valid held: second accepted in done cycle c5
        run_cmd("b2b", 4'd3, 4'd1, 10, 6, 16'h01CE, 16'h0210, 16'h0108, 16'h0420, 16'h03DE);
        chk("b2b count", bus.run_count, 32'd4);
        step();
        chk("b2b idle busy", bus.busy, 32'd0);
        chk("b2b idle X",    bus.X,    32'd0);

        // len=8 gap=1 with reset in the 4th HIGH cycle
        bus.cmd_len   = 4'd8;
        bus.cmd_gap   = 4'd1;
        bus.cmd_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) bus.cmd_valid = 1'b0;
            chk($sformatf("abort X c%0d", c), bus.X, 32'd1);
        end
        chk("abort z2 c4", bus.pred_z2, 32'd1);
        reset = 1'b1;
        step();
        chk("abort X c5",     bus.X,         32'd0);
        chk("abort busy c5",  bus.busy,      32'd0);
        chk("abort z1 c5",    bus.pred_z1,   32'd0);
        chk("abort z2 c5",    bus.pred_z2,   32'd0);
        chk("abort count c5", bus.run_count, 32'd0);
        chk("abort ready c5", bus.cmd_ready, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort ready rel", bus.cmd_ready, 32'd1);
        for (int c = 6; c <= 8; c++) begin
            step();
            chk($sformatf("dropped X c%0d", c),    bus.X,    32'd0);
            chk($sformatf("dropped done c%0d", c), bus.done, 32'd0);
        end

        // Saturation: len=2 gap=0 repeated, one z1 every 4 cycles
        bus.cmd_len   = 4'd2;
        bus.cmd_gap   = 4'd0;
        bus.cmd_valid = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("sat count 40", bus.run_count, 32'd10);
        repeat (1060) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (8) step();
        chk("sat count max", bus.run_count, 32'd255);
        chk("sat idle busy", bus.busy,      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
